// File: rtl/reg_scoreboard.sv
// Register-hazard scoreboard: one pending-write counter per GPR, stalls ID on
// RAW hazards against in-flight writes and on saturated destination counters.

// Per-register pending-write counter with overflow/underflow detection.
module reg_sb_cnt #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf,
  output logic             unf
);
  localparam logic [CNT_W-1:0] MAX = '1;

  // Simultaneous inc/dec cancel, so only a lone inc/dec can over/underflow.
  assign ovf = inc & ~dec & (cnt == MAX);
  assign unf = dec & ~inc & (cnt == '0);

  // Counter update; flush and reset both discard pending writes.
  always_ff @(posedge clk) begin
    if (reset || flush)             cnt <= '0;
    else if (inc && !dec && !ovf)   cnt <= cnt + 1'b1;
    else if (dec && !inc && !unf)   cnt <= cnt - 1'b1;
  end
endmodule

module reg_scoreboard #(
  parameter int CNT_W = 2,
  parameter int NREG  = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       id_src1_used,
  input  logic [4:0] id_src1,
  input  logic       id_src2_used,
  input  logic [4:0] id_src2,
  input  logic       id_src3_used,
  input  logic [4:0] id_src3,
  input  logic       id_dest_wen,
  input  logic [4:0] id_dest,
  input  logic       id_issue_fire,
  input  logic       wb_retire_fire,
  input  logic       wb_dest_wen,
  input  logic [4:0] wb_dest,
  input  logic       flush,
  output logic       id_stall,
  output logic       sb_busy,
  output logic       sb_err
);
  localparam logic [CNT_W-1:0] MAX = '1;

  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc_vec, dec_vec, ovf, unf;
  logic                       inc, dec;
  logic                       hit1, hit2, hit3, sat;

  assign inc = id_issue_fire & id_dest_wen & (id_dest != 5'd0);
  assign dec = wb_retire_fire & wb_dest_wen & (wb_dest != 5'd0);

  // One-hot decode of the issuing and retiring destinations.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    if (inc) inc_vec[id_dest] = 1'b1;
    if (dec) dec_vec[wb_dest] = 1'b1;
  end

  // r0 is hardwired zero and never tracked.
  assign cnt[0] = '0;
  assign ovf[0] = 1'b0;
  assign unf[0] = 1'b0;

  for (genvar g = 1; g < NREG; g++) begin : g_cnt
    reg_sb_cnt #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .inc   (inc_vec[g]),
      .dec   (dec_vec[g]),
      .cnt   (cnt[g]),
      .ovf   (ovf[g]),
      .unf   (unf[g])
    );
  end

  // Source hits and destination saturation; cnt[0] is zero so r0 never hits.
  always_comb begin
    hit1     = id_src1_used & (cnt[id_src1] != '0);
    hit2     = id_src2_used & (cnt[id_src2] != '0);
    hit3     = id_src3_used & (cnt[id_src3] != '0);
    sat      = id_dest_wen & (id_dest != 5'd0) & (cnt[id_dest] == MAX);
    id_stall = hit1 | hit2 | hit3 | sat;
  end

  assign sb_busy = |cnt;

  // Sticky protocol-error flag; survives flush, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset)                          sb_err <= 1'b0;
    else if (!flush && (|ovf || |unf))  sb_err <= 1'b1;
  end
endmodule

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench: driver pushes expected outputs from a counting model,
// a monitor pops and compares every cycle.
module tb_reg_scoreboard;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_src1_used, id_src2_used, id_src3_used, id_dest_wen, id_issue_fire;
  logic [4:0] id_src1, id_src2, id_src3, id_dest, wb_dest;
  logic       wb_retire_fire, wb_dest_wen, flush;
  logic       id_stall, sb_busy, sb_err;

  typedef struct {
    bit rst, fl;
    bit u1, u2, u3; int s1, s2, s3;
    bit wen, fire;  int d;
    bit rfire, rwen; int rd;
  } stim_t;

  typedef struct { bit stall, busy, err; } exp_t;

  exp_t expq[$];
  int   cnt_m[32];
  bit   err_m;
  int   n_cmp = 0, n_bad = 0;

  always #5 clk = ~clk;

  reg_scoreboard dut (
    .clk(clk), .reset(reset),
    .id_src1_used(id_src1_used), .id_src1(id_src1),
    .id_src2_used(id_src2_used), .id_src2(id_src2),
    .id_src3_used(id_src3_used), .id_src3(id_src3),
    .id_dest_wen(id_dest_wen), .id_dest(id_dest), .id_issue_fire(id_issue_fire),
    .wb_retire_fire(wb_retire_fire), .wb_dest_wen(wb_dest_wen), .wb_dest(wb_dest),
    .flush(flush), .id_stall(id_stall), .sb_busy(sb_busy), .sb_err(sb_err)
  );

  function automatic stim_t idle();
    stim_t s;
    s.rst = 0; s.fl = 0;
    s.u1 = 0; s.u2 = 0; s.u3 = 0; s.s1 = 0; s.s2 = 0; s.s3 = 0;
    s.wen = 0; s.fire = 0; s.d = 0;
    s.rfire = 0; s.rwen = 0; s.rd = 0;
    return s;
  endfunction

  function automatic stim_t issue(int d);
    stim_t s = idle();
    s.wen = 1; s.fire = 1; s.d = d;
    return s;
  endfunction

  function automatic stim_t retire(int d);
    stim_t s = idle();
    s.rfire = 1; s.rwen = 1; s.rd = d;
    return s;
  endfunction

  function automatic stim_t read1(int r);
    stim_t s = idle();
    s.u1 = 1; s.s1 = r;
    return s;
  endfunction

  // A register has a hazard if a pending write to it exists; r0 never counts.
  function automatic bit pending(int r);
    return (r != 0) && (cnt_m[r] > 0);
  endfunction

  function automatic bit model_stall(stim_t s);
    bit full = s.wen && s.d != 0 && cnt_m[s.d] == 3;
    return (s.u1 && pending(s.s1)) || (s.u2 && pending(s.s2)) ||
           (s.u3 && pending(s.s3)) || full;
  endfunction

  function automatic bit model_busy();
    foreach (cnt_m[i]) if (cnt_m[i] != 0) return 1;
    return 0;
  endfunction

  function automatic void model_update(stim_t s);
    int w = (s.fire && s.wen && s.d != 0) ? s.d : -1;
    int r = (s.rfire && s.rwen && s.rd != 0) ? s.rd : -1;
    if (s.rst) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
      err_m = 0;
    end else if (s.fl) begin
      foreach (cnt_m[i]) cnt_m[i] = 0;
    end else if (!(w >= 0 && w == r)) begin
      if (w >= 0) begin
        if (cnt_m[w] == 3) err_m = 1; else cnt_m[w]++;
      end
      if (r >= 0) begin
        if (cnt_m[r] == 0) err_m = 1; else cnt_m[r]--;
      end
    end
  endfunction

  task automatic step(input stim_t s);
    exp_t e;
    @(posedge clk); #1;
    reset = s.rst; flush = s.fl;
    id_src1_used = s.u1; id_src1 = 5'(s.s1);
    id_src2_used = s.u2; id_src2 = 5'(s.s2);
    id_src3_used = s.u3; id_src3 = 5'(s.s3);
    id_dest_wen = s.wen; id_dest = 5'(s.d); id_issue_fire = s.fire;
    wb_retire_fire = s.rfire; wb_dest_wen = s.rwen; wb_dest = 5'(s.rd);
    e.stall = model_stall(s);
    e.busy  = model_busy();
    e.err   = err_m;
    expq.push_back(e);
    model_update(s);
  endtask

  function automatic int pick_reg();
    return ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31))
                                        : int'($urandom_range(0, 7));
  endfunction

  // legal=1 keeps ID and WB within protocol so sb_err stays meaningful.
  task automatic rand_step(input bit legal);
    stim_t s = idle();
    int live[$];
    s.u1 = 1'($urandom); s.s1 = pick_reg();
    s.u2 = 1'($urandom); s.s2 = pick_reg();
    s.u3 = 1'($urandom); s.s3 = pick_reg();
    s.wen = 1'($urandom); s.d = pick_reg();
    s.fire = 1'($urandom);
    if (legal && model_stall(s)) s.fire = 0;
    s.rfire = 1'($urandom); s.rwen = 1'($urandom);
    s.rd = pick_reg();
    if (legal) begin
      foreach (cnt_m[i]) if (i != 0 && cnt_m[i] > 0) live.push_back(i);
      if (live.size() > 0) s.rd = live[$urandom_range(0, live.size() - 1)];
      else s.rwen = 0;
    end
    s.fl  = ($urandom_range(0, 39) == 0);
    s.rst = !legal && ($urandom_range(0, 149) == 0);
    step(s);
  endtask

  task automatic chk(input string name, input bit act, input bit req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("id_stall", id_stall, e.stall);
        chk("sb_busy",  sb_busy,  e.busy);
        chk("sb_err",   sb_err,   e.err);
      end
    end
  end

  initial begin
    stim_t s;
    s = idle();
    reset = 1; flush = 0;
    id_src1_used = 0; id_src1 = 0; id_src2_used = 0; id_src2 = 0;
    id_src3_used = 0; id_src3 = 0; id_dest_wen = 0; id_dest = 0;
    id_issue_fire = 0; wb_retire_fire = 0; wb_dest_wen = 0; wb_dest = 0;
    foreach (cnt_m[i]) cnt_m[i] = 0;
    err_m = 0;
    repeat (2) @(posedge clk);

    // Idle after reset.
    repeat (10) step(idle());

    // RAW on r5: visible the cycle after issue, cleared the cycle after retire.
    step(issue(5));
    step(read1(5));
    step(read1(5));
    s = retire(5); s.u1 = 1; s.s1 = 5; step(s);
    step(read1(5));

    // Saturate r7, then force a protocol-violating issue.
    repeat (3) step(issue(7));
    s = idle(); s.wen = 1; s.d = 7; step(s);
    step(issue(7));
    s = idle(); s.wen = 1; s.d = 7; step(s);
    repeat (3) step(retire(7));
    step(read1(7));

    // Same-cycle inc/dec on one register and on different registers.
    step(issue(9));
    s = retire(9); s.wen = 1; s.fire = 1; s.d = 9; step(s);
    step(read1(9));
    step(issue(4));
    s = retire(4); s.wen = 1; s.fire = 1; s.d = 3; step(s);
    step(read1(3));
    step(read1(4));
    step(retire(9));
    step(retire(3));

    // Flush overrides a concurrent issue.
    step(issue(1)); step(issue(2)); step(issue(31));
    s = issue(6); s.fl = 1; step(s);
    step(read1(6));

    // r0 never counts; underflow sets the sticky error.
    s = idle(); s.rst = 1; step(s);
    repeat (4) begin
      s = issue(0); s.u1 = 1; s.u2 = 1; s.u3 = 1; step(s);
    end
    step(retire(10));
    step(read1(10));
    s = idle(); s.fl = 1; step(s);
    step(idle());

    // Randomized traffic: protocol-clean, then with violations and resets.
    s = idle(); s.rst = 1; step(s);
    repeat (1500) rand_step(1'b1);
    s = idle(); s.rst = 1; step(s);
    repeat (1000) rand_step(1'b0);
    step(idle());

    repeat (3) @(posedge clk);
    n_cmp++;
    if (expq.size() != 0) begin
      n_bad++;
      $display("FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
